// File: rtl/agusec_check_sched_if.sv
// Request/checker/result bundle shared between the AGU issue ports,
// the pointer-range checker and the LSQ fault path.
interface agusec_check_sched_if #(
    parameter int NREQ = 3,
    parameter int TAGW = 9,
    parameter int CNTW = 16
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*64-1:0]   req_ptr;
    logic [NREQ*TAGW-1:0] req_tag;
    logic [NREQ-1:0]      req_ready;

    logic [63:0]          chk_ptr;
    logic                 chk_cin;
    logic                 chk_ok;

    logic                 flush;
    logic                 res_stall;
    logic                 res_valid;
    logic                 res_ok;
    logic [TAGW-1:0]      res_tag;
    logic [1:0]           res_port;

    logic                 fault_valid;
    logic [TAGW-1:0]      fault_tag;
    logic [1:0]           fault_port;
    logic                 fault_clr;
    logic [CNTW-1:0]      viol_cnt;

    // Scheduler side
    modport slave (
        input  req_valid, req_ptr, req_tag, chk_ok, flush, res_stall, fault_clr,
        output req_ready, chk_ptr, chk_cin, res_valid, res_ok, res_tag, res_port,
               fault_valid, fault_tag, fault_port, viol_cnt
    );

    // Requester / checker / consumer side
    modport master (
        output req_valid, req_ptr, req_tag, chk_ok, flush, res_stall, fault_clr,
        input  req_ready, chk_ptr, chk_cin, res_valid, res_ok, res_tag, res_port,
               fault_valid, fault_tag, fault_port, viol_cnt
    );
endinterface

// File: rtl/agusec_check_sched.sv
// Round-robin scheduler sharing one combinational pointer-range checker
// between NREQ AGU ports; registers tagged verdicts and tracks violations.
module agusec_check_sched #(
    parameter int NREQ = 3,
    parameter int TAGW = 9,
    parameter int CNTW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    agusec_check_sched_if.slave   bus
);
    localparam logic [1:0] LAST_PORT = 2'(NREQ - 1);
    localparam logic [2:0] NREQ_W    = 3'(NREQ);

    logic [63:0]     ptr_arr [NREQ];
    logic [TAGW-1:0] tag_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign ptr_arr[gi] = bus.req_ptr[64*gi +: 64];
            assign tag_arr[gi] = bus.req_tag[TAGW*gi +: TAGW];
        end
    endgenerate

    logic [1:0]      rr_ptr_q,      rr_ptr_d;
    logic            res_valid_q,   res_valid_d;
    logic            res_ok_q,      res_ok_d;
    logic [TAGW-1:0] res_tag_q,     res_tag_d;
    logic [1:0]      res_port_q,    res_port_d;
    logic            fault_valid_q, fault_valid_d;
    logic [TAGW-1:0] fault_tag_q,   fault_tag_d;
    logic [1:0]      fault_port_q,  fault_port_d;
    logic [CNTW-1:0] viol_cnt_q,    viol_cnt_d;

    logic            can_issue;
    logic            found;
    logic            grant_ok;
    logic [1:0]      gnt_idx;
    logic [2:0]      cand;
    logic [NREQ-1:0] grant;
    logic            viol;

    // A held result blocks new issue, and nothing is issued while reset is high.
    assign can_issue = ~rst & ~bus.flush & ~(res_valid_q & bus.res_stall);

    // First valid port at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 3'(rr_ptr_q) + 3'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && bus.req_valid[cand[1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[1:0];
            end
        end
    end

    assign grant_ok = found & can_issue;
    assign viol     = grant_ok & ~bus.chk_ok;

    always_comb begin
        grant = '0;
        if (grant_ok) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = grant;
    assign bus.chk_cin   = grant_ok;
    assign bus.chk_ptr   = grant_ok ? ptr_arr[gnt_idx] : 64'd0;

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        res_valid_d   = 1'b0;
        res_ok_d      = res_ok_q;
        res_tag_d     = res_tag_q;
        res_port_d    = res_port_q;
        fault_valid_d = fault_valid_q;
        fault_tag_d   = fault_tag_q;
        fault_port_d  = fault_port_q;
        viol_cnt_d    = viol_cnt_q;

        if (grant_ok) begin
            res_valid_d = 1'b1;
            res_ok_d    = bus.chk_ok;
            res_tag_d   = tag_arr[gnt_idx];
            res_port_d  = gnt_idx;
            rr_ptr_d    = (gnt_idx == LAST_PORT) ? 2'd0 : gnt_idx + 2'd1;
        end else if (!bus.flush && res_valid_q && bus.res_stall) begin
            res_valid_d = 1'b1;
        end

        if (viol && viol_cnt_q != {CNTW{1'b1}}) begin
            viol_cnt_d = viol_cnt_q + 1'b1;
        end

        // A clear in the same cycle as a new violation re-arms on that violation.
        if (viol && (!fault_valid_q || bus.fault_clr)) begin
            fault_valid_d = 1'b1;
            fault_tag_d   = tag_arr[gnt_idx];
            fault_port_d  = gnt_idx;
        end else if (bus.fault_clr) begin
            fault_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            res_valid_q   <= 1'b0;
            res_ok_q      <= 1'b0;
            res_tag_q     <= '0;
            res_port_q    <= '0;
            fault_valid_q <= 1'b0;
            fault_tag_q   <= '0;
            fault_port_q  <= '0;
            viol_cnt_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            res_valid_q   <= res_valid_d;
            res_ok_q      <= res_ok_d;
            res_tag_q     <= res_tag_d;
            res_port_q    <= res_port_d;
            fault_valid_q <= fault_valid_d;
            fault_tag_q   <= fault_tag_d;
            fault_port_q  <= fault_port_d;
            viol_cnt_q    <= viol_cnt_d;
        end
    end

    assign bus.res_valid   = res_valid_q;
    assign bus.res_ok      = res_ok_q;
    assign bus.res_tag     = res_tag_q;
    assign bus.res_port    = res_port_q;
    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_tag   = fault_tag_q;
    assign bus.fault_port  = fault_port_q;
    assign bus.viol_cnt    = viol_cnt_q;
endmodule

// File: tb/tb_agusec_check_sched.sv
// Directed bench for agusec_check_sched: expected results are queued at
// accept time and compared one cycle later when the result register loads.
module tb_agusec_check_sched;
    localparam int NREQ = 3;
    localparam int TAGW = 9;
    localparam int CNTW = 4;

    typedef struct packed {
        logic            ok;
        logic [TAGW-1:0] tag;
        logic [1:0]      port;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    agusec_check_sched_if #(.NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW)) bus ();

    agusec_check_sched #(.NREQ(NREQ), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0] v     = '0;
    logic [63:0]     ptr [NREQ];
    logic [TAGW-1:0] tag [NREQ];
    logic            ok    = 1'b1;
    logic            flush = 1'b0;
    logic            stall = 1'b0;
    logic            fclr  = 1'b0;

    assign bus.req_valid = v;
    assign bus.req_ptr   = {ptr[2], ptr[1], ptr[0]};
    assign bus.req_tag   = {tag[2], tag[1], tag[0]};
    assign bus.chk_ok    = ok;
    assign bus.flush     = flush;
    assign bus.res_stall = stall;
    assign bus.fault_clr = fclr;

    int   total = 0;
    int   bad   = 0;
    exp_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: check arbitration mid-cycle, then the registered result.
    task automatic cyc(input logic [NREQ-1:0] exp_rdy);
        logic [1:0] p;
        logic       acc;
        exp_t       e;
        p = 2'd0;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) p = 2'(i);
        @(negedge clk);
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("chk_cin",   64'(bus.chk_cin),   64'(|exp_rdy));
        chk("chk_ptr",   bus.chk_ptr,        (exp_rdy != '0) ? ptr[p] : 64'd0);
        acc = (exp_rdy != '0);
        if (acc) sb.push_back('{ok: ok, tag: tag[p], port: p});
        @(posedge clk);
        #1;
        if (acc) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                chk("res_valid", 64'(bus.res_valid), 64'd1);
                chk("res_ok",    64'(bus.res_ok),    64'(e.ok));
                chk("res_tag",   64'(bus.res_tag),   64'(e.tag));
                chk("res_port",  64'(bus.res_port),  64'(e.port));
                $display("result port=%0d tag=%03h ok=%0b cnt=%0d",
                         bus.res_port, bus.res_tag, bus.res_ok, bus.viol_cnt);
            end
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_res_valid",   64'(bus.res_valid),   64'd0);
        chk("rst_res_ok",      64'(bus.res_ok),      64'd0);
        chk("rst_res_tag",     64'(bus.res_tag),     64'd0);
        chk("rst_res_port",    64'(bus.res_port),    64'd0);
        chk("rst_fault_valid", 64'(bus.fault_valid), 64'd0);
        chk("rst_fault_tag",   64'(bus.fault_tag),   64'd0);
        chk("rst_fault_port",  64'(bus.fault_port),  64'd0);
        chk("rst_viol_cnt",    64'(bus.viol_cnt),    64'd0);
    endtask

    initial begin
        ptr[0] = 64'hA000_0000_0000_1000; tag[0] = 9'h012;
        ptr[1] = 64'hB111_2222_3333_4444; tag[1] = 9'h034;
        ptr[2] = 64'hC555_6666_7777_8888; tag[2] = 9'h156;

        // Reset: ready stays low even with all ports requesting
        v = 3'b111;
        cyc(3'b000);
        cyc(3'b000);
        chk_reset_state();

        // Single request on port 0, one-cycle result latency
        rst = 1'b0;
        v = 3'b001;
        cyc(3'b001);
        v = 3'b000;
        cyc(3'b000);
        chk("res_valid_drop", 64'(bus.res_valid), 64'd0);

        // Round robin from a fresh reset pointer
        rst = 1'b1;
        cyc(3'b000);
        rst = 1'b0;
        v = 3'b111;
        cyc(3'b001); cyc(3'b010); cyc(3'b100);
        cyc(3'b001); cyc(3'b010); cyc(3'b100);

        // Backpressure: result held, no issue, waiting port resumes
        cyc(3'b001);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(3'b000);
            chk("stall_valid", 64'(bus.res_valid), 64'd1);
            chk("stall_tag",   64'(bus.res_tag),   64'h012);
            chk("stall_port",  64'(bus.res_port),  64'd0);
        end
        stall = 1'b0;
        cyc(3'b010);

        // Sticky first-violation record
        ok = 1'b0;
        v = 3'b010; tag[1] = 9'h005;
        cyc(3'b010);
        v = 3'b100; tag[2] = 9'h007;
        cyc(3'b100);
        chk("fault_valid", 64'(bus.fault_valid), 64'd1);
        chk("fault_tag",   64'(bus.fault_tag),   64'h005);
        chk("fault_port",  64'(bus.fault_port),  64'd1);
        chk("viol_cnt2",   64'(bus.viol_cnt),    64'd2);
        fclr = 1'b1;
        v = 3'b001; tag[0] = 9'h009;
        cyc(3'b001);
        chk("clr_viol_valid", 64'(bus.fault_valid), 64'd1);
        chk("clr_viol_tag",   64'(bus.fault_tag),    64'h009);
        chk("clr_viol_port",  64'(bus.fault_port),   64'd0);
        chk("viol_cnt3",      64'(bus.viol_cnt),     64'd3);
        v = 3'b000;
        cyc(3'b000);
        chk("clr_only_valid", 64'(bus.fault_valid), 64'd0);
        chk("clr_only_tag",   64'(bus.fault_tag),   64'h009);
        fclr = 1'b0;

        // Flush after an accept while stalled; pointer must not move
        ok = 1'b1;
        v = 3'b010;
        cyc(3'b010);
        stall = 1'b1; flush = 1'b1; v = 3'b111;
        cyc(3'b000);
        chk("flush_valid", 64'(bus.res_valid), 64'd0);
        stall = 1'b0; flush = 1'b0;
        cyc(3'b100);

        // Saturate the violation counter
        ok = 1'b0;
        v = 3'b001;
        for (int i = 0; i < 12; i++) cyc(3'b001);
        chk("viol_cnt_full", 64'(bus.viol_cnt), 64'hF);
        cyc(3'b001);
        chk("viol_cnt_sat", 64'(bus.viol_cnt), 64'hF);

        // Reset mid-stream
        ok = 1'b1;
        v = 3'b111;
        cyc(3'b010);
        rst = 1'b1;
        cyc(3'b000);
        chk_reset_state();
        rst = 1'b0;
        cyc(3'b001);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
